// File: rtl/stack_node_p_if.sv
// Handshake bundle between a stack_node_p and its NPORTS neighbours.
// master = storage node side, slave = neighbour side.
interface stack_node_p_if #(
  parameter int WIDTH  = 11,
  parameter int NPORTS = 4
);
  logic [NPORTS-1:0]       rready;
  logic [NPORTS*WIDTH-1:0] rdata;
  logic [NPORTS-1:0]       read;
  logic [NPORTS-1:0]       wready;
  logic [WIDTH-1:0]        out;
  logic [NPORTS-1:0]       write;

  modport master (input rready, rdata, wready, output read, out, write);
  modport slave  (output rready, rdata, wready, input read, out, write);
endinterface

// File: rtl/stack_node_p.sv
// Parametrised LIFO/FIFO storage node for the TIS grid with a single registered offer slot.
// Define STACK_NODE_FLUSH_EN to add the synchronous flush input.
module stack_node_p #(
  parameter int WIDTH  = 11,
  parameter int DEPTH  = 15,
  parameter int NPORTS = 4,
  parameter int MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  stack_node_p_if.master             bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
`ifdef STACK_NODE_FLUSH_EN
  ,
  input  logic                       flush
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NPORTS-1:0] read_q, read_d, write_q, write_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [0:0]        state_q, state_d;

  logic              push, load, flush_now;
  logic [NPORTS-1:0] avail;
  logic [IW-1:0]     sel;
  logic [PW-1:0]     waddr, raddr;
  logic [WIDTH-1:0]  wdata;

`ifdef STACK_NODE_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // A port still showing its read pulse is masked so one handshake never consumes twice.
  assign avail = bus.rready & ~read_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = !full && (|avail) && !flush_now;
  assign load  = (state_q == IDLE) && !empty && !flush_now;

  always_comb begin
    sel = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (avail[i]) sel = IW'(i);
    end
  end

  assign wdata = bus.rdata[int'(sel)*WIDTH +: WIDTH];

  // LIFO: a simultaneous push overwrites the slot the load just vacated, so the top stays put.
  if (MODE == 0) begin : g_lifo
    assign raddr = PW'(count_q - 1'b1);
    assign waddr = load ? raddr : PW'(count_q);
  end else begin : g_fifo
    assign raddr = rd_ptr_q;
    assign waddr = wr_ptr_q;
  end

  always_comb begin
    count_d  = count_q + CW'(push) - CW'(load);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    read_d   = '0;
    write_d  = write_q;
    out_d    = out_q;
    idx_d    = idx_q;
    state_d  = state_q;

    if (push) begin
      read_d   = NPORTS'(1) << sel;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (load) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          out_d   = mem_q[raddr];
          write_d = NPORTS'(1);
          idx_d   = '0;
          state_d = OFFER;
        end
      end
      default: begin
        if (|(bus.wready & write_q)) begin
          write_d = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = (idx_q == IW'(NPORTS - 1)) ? '0 : idx_q + 1'b1;
          write_d = NPORTS'(1) << idx_d;
        end
      end
    endcase

    // Flush drops everything except the stale word left in out.
    if (flush_now) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      read_d   = '0;
      write_d  = '0;
      idx_d    = '0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      read_q   <= '0;
      write_q  <= '0;
      out_q    <= '0;
      idx_q    <= '0;
      state_q  <= IDLE;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      out_q    <= out_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[waddr] <= wdata;
  end

  assign bus.read  = read_q;
  assign bus.write = write_q;
  assign bus.out   = out_q;
  assign count     = count_q;
endmodule

// File: tb/tb_stack_node_p.sv
// Bench for stack_node_p: one LIFO and one FIFO instance, table-driven vectors plus a transfer scoreboard.
// Also exercises flush when STACK_NODE_FLUSH_EN is defined.
module tb_stack_node_p;
  localparam int W = 11;
  localparam int D = 15;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef STACK_NODE_FLUSH_EN
  logic flush = 1'b0;
`endif

  stack_node_p_if #(.WIDTH(W), .NPORTS(N)) if_l ();
  stack_node_p_if #(.WIDTH(W), .NPORTS(N)) if_f ();

  logic [3:0] count_l, count_f;
  logic       full_l, full_f, empty_l, empty_f;

  stack_node_p #(.WIDTH(W), .DEPTH(D), .NPORTS(N), .MODE(0)) dut_l (
    .clk(clk), .rst(rst), .bus(if_l), .count(count_l), .full(full_l), .empty(empty_l)
`ifdef STACK_NODE_FLUSH_EN
    , .flush(flush)
`endif
  );

  stack_node_p #(.WIDTH(W), .DEPTH(D), .NPORTS(N), .MODE(1)) dut_f (
    .clk(clk), .rst(rst), .bus(if_f), .count(count_f), .full(full_f), .empty(empty_f)
`ifdef STACK_NODE_FLUSH_EN
    , .flush(flush)
`endif
  );

  typedef struct {
    logic [3:0]  rready;
    logic [3:0]  wready;
    logic [3:0]  exp_read;
    logic [3:0]  exp_write;
    logic [10:0] exp_out;
    logic [3:0]  exp_count;
  } vec_t;

  vec_t        vecs[13];
  logic [10:0] exp_l[$];
  logic [10:0] exp_f[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    if_f.rready = v.rready;
    if_f.wready = v.wready;
    step();
  endtask

  task automatic lstep(input logic [3:0] rr, input logic [3:0] wr);
    if_l.rready = rr;
    if_l.wready = wr;
    step();
  endtask

  task automatic fstep(input logic [3:0] rr, input logic [3:0] wr);
    if_f.rready = rr;
    if_f.wready = wr;
    step();
  endtask

  // Scoreboard: every accepted offer must match the next word the bench expects.
  always @(negedge clk) begin
    if (!rst && |(if_f.wready & if_f.write)) begin
      if (exp_f.size() == 0) checkOutput("fifo_xfer_unexpected", 32'(if_f.out), 32'hFFFF_FFFF);
      else checkOutput("fifo_xfer", 32'(if_f.out), 32'(exp_f.pop_front()));
    end
    if (!rst && |(if_l.wready & if_l.write)) begin
      if (exp_l.size() == 0) checkOutput("lifo_xfer_unexpected", 32'(if_l.out), 32'hFFFF_FFFF);
      else checkOutput("lifo_xfer", 32'(if_l.out), 32'(exp_l.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // FIFO, all four ports raised at once; neighbours drop rready a cycle after seeing read.
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 11'd0,   4'd1};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001, 11'd10,  4'd1};
    vecs[2]  = '{4'b1110, 4'b0000, 4'b0100, 4'b0010, 11'd10,  4'd2};
    vecs[3]  = '{4'b1100, 4'b0000, 4'b1000, 4'b0100, 11'd10,  4'd3};
    vecs[4]  = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 11'd10,  4'd3};
    vecs[5]  = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 11'd10,  4'd3};
    vecs[6]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0001, 11'd20,  4'd2};
    vecs[7]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 11'd20,  4'd2};
    vecs[8]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0001, 11'd30,  4'd1};
    vecs[9]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 11'd30,  4'd1};
    vecs[10] = '{4'b0000, 4'b1111, 4'b0000, 4'b0001, 11'h7FD, 4'd0};
    vecs[11] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 11'h7FD, 4'd0};
    vecs[12] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 11'h7FD, 4'd0};

    if_l.rready = '0; if_l.wready = '0; if_l.rdata = '0;
    if_f.rready = '0; if_f.wready = '0; if_f.rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_write_l", 32'(if_l.write), 32'd0);
    checkOutput("rst_read_l",  32'(if_l.read),  32'd0);
    checkOutput("rst_out_l",   32'(if_l.out),   32'd0);
    checkOutput("rst_count_l", 32'(count_l),    32'd0);
    checkOutput("rst_empty_f", 32'(empty_f),    32'd1);
    checkOutput("rst_full_f",  32'(full_f),     32'd0);

    // Table: simultaneous rready, masking, rotation, FIFO order, signed passthrough.
    if_f.rdata = {11'h7FD, 11'd30, 11'd20, 11'd10};
    exp_f.push_back(11'd10);
    exp_f.push_back(11'd20);
    exp_f.push_back(11'd30);
    exp_f.push_back(11'h7FD);
    for (int r = 0; r < 13; r++) begin
      applyStimulus(vecs[r]);
      checkOutput($sformatf("tbl%0d_read", r),  32'(if_f.read),  32'(vecs[r].exp_read));
      checkOutput($sformatf("tbl%0d_write", r), 32'(if_f.write), 32'(vecs[r].exp_write));
      checkOutput($sformatf("tbl%0d_out", r),   32'(if_f.out),   32'(vecs[r].exp_out));
      checkOutput($sformatf("tbl%0d_count", r), 32'(count_f),    32'(vecs[r].exp_count));
      checkOutput($sformatf("tbl%0d_empty", r), 32'(empty_f),    32'(vecs[r].exp_count == 4'd0));
    end

    // FIFO fill with the out slot busy, then a held rready that must wait for space.
    for (int k = 0; k < 16; k++) begin
      if_f.rdata[W-1:0] = W'(100 + k);
      exp_f.push_back(W'(100 + k));
      fstep(4'b0001, 4'b0000);
      checkOutput($sformatf("fill%0d_read", k), 32'(if_f.read), 32'd1);
      fstep(4'b0000, 4'b0000);
    end
    checkOutput("fill_count", 32'(count_f), 32'd15);
    checkOutput("fill_full",  32'(full_f),  32'd1);
    if_f.rdata[W-1:0] = W'(116);
    exp_f.push_back(W'(116));
    for (int k = 0; k < 3; k++) begin
      fstep(4'b0001, 4'b0000);
      checkOutput($sformatf("full_hold%0d_read", k), 32'(if_f.read), 32'd0);
    end
    fstep(4'b0001, 4'b1111);
    checkOutput("full_acc_read",  32'(if_f.read),  32'd0);
    checkOutput("full_acc_count", 32'(count_f),    32'd15);
    checkOutput("full_acc_write", 32'(if_f.write), 32'd0);
    fstep(4'b0001, 4'b1111);
    checkOutput("full_load_read",  32'(if_f.read), 32'd0);
    checkOutput("full_load_count", 32'(count_f),   32'd14);
    checkOutput("full_load_full",  32'(full_f),    32'd0);
    fstep(4'b0001, 4'b1111);
    checkOutput("full_push_read",  32'(if_f.read), 32'd1);
    checkOutput("full_push_count", 32'(count_f),   32'd15);
    for (int k = 0; k < 40; k++) fstep(4'b0000, 4'b1111);
    checkOutput("drain_count", 32'(count_f), 32'd0);
    checkOutput("drain_empty", 32'(empty_f), 32'd1);
    checkOutput("drain_left_f", 32'(exp_f.size()), 32'd0);
    fstep(4'b0000, 4'b0000);

    // LIFO: filler 7 occupies out, then 5 and 9 stacked; 9 offered with rotating write.
    exp_l.push_back(11'd7);
    exp_l.push_back(11'd9);
    exp_l.push_back(11'd5);
    if_l.rdata = {11'd0, 11'd9, 11'd5, 11'd7};
    lstep(4'b0001, 4'b0000);
    lstep(4'b0000, 4'b0000);
    checkOutput("l_filler_out", 32'(if_l.out), 32'd7);
    lstep(4'b0010, 4'b0000);
    lstep(4'b0100, 4'b0000);
    checkOutput("l_stack_count", 32'(count_l), 32'd2);
    lstep(4'b0000, 4'b1111);
    checkOutput("l_acc_write", 32'(if_l.write), 32'd0);
    lstep(4'b0000, 4'b0000);
    checkOutput("l_top_out",   32'(if_l.out),   32'd9);
    checkOutput("l_top_write", 32'(if_l.write), 32'd1);
    checkOutput("l_top_count", 32'(count_l),    32'd1);
    begin
      logic [3:0] rot [6];
      rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      for (int k = 0; k < 6; k++) begin
        lstep(4'b0000, 4'b0000);
        checkOutput($sformatf("l_rot%0d_write", k), 32'(if_l.write), 32'(rot[k]));
      end
    end
    lstep(4'b0000, 4'b0100);
    checkOutput("l_xfer9_write", 32'(if_l.write), 32'd0);
    checkOutput("l_xfer9_count", 32'(count_l),    32'd1);
    lstep(4'b0000, 4'b0000);
    checkOutput("l_next_out",   32'(if_l.out),   32'd5);
    checkOutput("l_next_write", 32'(if_l.write), 32'd1);
    checkOutput("l_next_empty", 32'(empty_l),    32'd1);
    lstep(4'b0000, 4'b0001);
    checkOutput("l_end_write", 32'(if_l.write), 32'd0);
    checkOutput("drain_left_l", 32'(exp_l.size()), 32'd0);

`ifdef STACK_NODE_FLUSH_EN
    // Flush mid-OFFER with a push pending: everything cleared except out.
    if_f.rdata = {11'd0, 11'd0, 11'd53, 11'd50};
    fstep(4'b0001, 4'b0000);
    fstep(4'b0000, 4'b0000);
    if_f.rdata[W-1:0] = 11'd51;
    fstep(4'b0001, 4'b0000);
    flush = 1'b1;
    fstep(4'b0010, 4'b0000);
    flush = 1'b0;
    checkOutput("flush_read",  32'(if_f.read),  32'd0);
    checkOutput("flush_write", 32'(if_f.write), 32'd0);
    checkOutput("flush_count", 32'(count_f),    32'd0);
    checkOutput("flush_out",   32'(if_f.out),   32'd50);
    fstep(4'b0000, 4'b0000);
    checkOutput("flush_idle_write", 32'(if_f.write), 32'd0);
`endif

    // Reset mid-OFFER with a read pulse outstanding: outputs clear without a clock edge.
    if_l.rdata[W-1:0] = 11'd1;
    lstep(4'b0001, 4'b0000);
    lstep(4'b0000, 4'b0000);
    if_l.rdata[W-1:0] = 11'd2;
    lstep(4'b0001, 4'b0000);
    checkOutput("pre_rst_read", 32'(if_l.read), 32'd1);
    if_l.rready = '0;
    rst = 1'b1;
    #1;
    checkOutput("arst_write", 32'(if_l.write), 32'd0);
    checkOutput("arst_read",  32'(if_l.read),  32'd0);
    checkOutput("arst_count", 32'(count_l),    32'd0);
    checkOutput("arst_out",   32'(if_l.out),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    checkOutput("post_rst_write", 32'(if_l.write), 32'd0);
    checkOutput("post_rst_empty", 32'(empty_l),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
